// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux
//   N-channel valid/ready arbiter feeding a single registered output slot.
//   Each cycle at most one requesting channel is granted. The grant is taken
//   only when the slot is empty or is draining in the same cycle, so a
//   continuously ready downstream sees one beat per clock.
//
//   Arbitration policy (MODE):
//     0 : round-robin. The search starts at ptr and wraps. After a grant to g,
//         ptr moves to (g+1) mod N.
//     1 : fixed priority. The lowest requesting index wins and ptr stays 0.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   reset      asynchronous, active-high; clears the slot and the pointer
//   in_data    N*WIDTH; channel i data is in bits [i*WIDTH +: WIDTH]
//   in_valid   N; channel i offers a beat
//   in_ready   N; one-hot grant, all zero when nothing can be accepted
//   out_data   WIDTH; registered data of the selected beat
//   out_valid  out_data / out_sel hold a valid beat
//   out_ready  downstream accepts the beat when out_valid & out_ready
//   out_sel    SW; index of the channel out_data came from
// -----------------------------------------------------------------------------
module arb_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SW    = (N < 2) ? 1 : $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_sel
);

    // Adds an offset in [0, N) to a channel index, wrapping modulo N.
    // This also works when N is not a power of two.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base,
                                               input int              off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return SW'(sum);
    endfunction

    // Unpacked view of the flat input bus, so that channel selection is a
    // plain array index.
    logic [WIDTH-1:0] chan_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    logic [SW-1:0] ptr;
    logic [SW-1:0] search_base;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic          can_load;
    logic          take;

    // In fixed-priority mode the search always starts at channel 0.
    assign search_base = (MODE == 1) ? '0 : ptr;

    // The slot can accept a new beat when it is empty or being drained now.
    assign can_load = !out_valid | out_ready;

    // Walks the search order from farthest to nearest. The last hit written
    // is therefore the first requester in search order, so no break flag is
    // needed.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[wrap_add(search_base, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_add(search_base, k);
            end
        end
    end

    // Gating with reset keeps in_ready at zero for the whole time reset is
    // asserted, not only after the flops have cleared.
    assign take = grant_any & can_load & !reset;

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments, so every flop samples
    // its inputs before any of them updates. This keeps simulation matching
    // hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (take) begin
            // This branch covers both a load into an empty slot and a
            // drain-and-replace in the same cycle.
            out_valid <= 1'b1;
            out_data  <= chan_data[grant_idx];
            out_sel   <= grant_idx;
            if (MODE == 0) begin
                ptr <= wrap_add(grant_idx, 1);
            end
        end else if (out_ready) begin
            // Drain with nothing to replace it. Data and sel keep their last
            // values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_mux
//   Drives a round-robin instance (MODE 0) and a fixed-priority instance
//   (MODE 1) with the same stimulus. Each instance is compared every cycle
//   against a behavioural model of the one-slot arbiter. Directed scenarios
//   with hand-computed literal values come first, then a randomized run with
//   occasional resets.
// -----------------------------------------------------------------------------
module tb_arb_mux;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [N*W-1:0]   in_data   = '0;
    logic [N-1:0]     in_valid  = '0;
    logic             out_ready = 1'b0;

    logic [N-1:0]     rr_in_ready, fp_in_ready;
    logic [W-1:0]     rr_out_data, fp_out_data;
    logic             rr_out_valid, fp_out_valid;
    logic [SW-1:0]    rr_out_sel, fp_out_sel;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rr_in_ready),
        .out_data  (rr_out_data),
        .out_valid (rr_out_valid),
        .out_ready (out_ready),
        .out_sel   (rr_out_sel)
    );

    arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u_fp (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (fp_in_ready),
        .out_data  (fp_out_data),
        .out_valid (fp_out_valid),
        .out_ready (out_ready),
        .out_sel   (fp_out_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = RR, 1 = FP) -------------
    logic         m_valid [2] = '{1'b0, 1'b0};
    logic [W-1:0] m_data  [2] = '{16'h0, 16'h0};
    int           m_sel   [2] = '{0, 0};
    int           m_ptr   [2] = '{0, 0};

    function automatic logic [W-1:0] word(input int g);
        return in_data[g*W +: W];
    endfunction

    // Requester at the smallest distance from the pointer (round-robin), or
    // the smallest index (fixed priority). Returns -1 when nothing is
    // requesting.
    function automatic int pick(input int m);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
                d = (m == 0) ? (i - m_ptr[m] + N) % N : i;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic can_take(input int m);
        return (!m_valid[m] || out_ready) && (pick(m) >= 0);
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        if (reset || !can_take(m)) begin
            return '0;
        end
        return N'(1) << pick(m);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                m_valid[m] <= 1'b0;
                m_data[m]  <= '0;
                m_sel[m]   <= 0;
                m_ptr[m]   <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (can_take(m)) begin
                    m_valid[m] <= 1'b1;
                    m_data[m]  <= word(pick(m));
                    m_sel[m]   <= pick(m);
                    m_ptr[m]   <= (m == 0) ? (pick(m) + 1) % N : 0;
                end else if (out_ready) begin
                    m_valid[m] <= 1'b0;
                end
            end
        end
    end

    // Compare process: outputs are stable on the falling edge.
    always @(negedge clk) begin
        check("rr out_valid", 32'(rr_out_valid), 32'(m_valid[0]));
        check("rr out_data",  32'(rr_out_data),  32'(m_data[0]));
        check("rr out_sel",   32'(rr_out_sel),   32'(m_sel[0]));
        check("rr in_ready",  32'(rr_in_ready),  32'(exp_ready(0)));
        check("fp out_valid", 32'(fp_out_valid), 32'(m_valid[1]));
        check("fp out_data",  32'(fp_out_data),  32'(m_data[1]));
        check("fp out_sel",   32'(fp_out_sel),   32'(m_sel[1]));
        check("fp in_ready",  32'(fp_in_ready),  32'(exp_ready(1)));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int g, input logic [W-1:0] v);
        in_data[g*W +: W] = v;
    endtask

    int seq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        // Reset, then idle.
        repeat (2) step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check("idle out_valid", 32'(rr_out_valid), 32'h0);
        check("idle out_data",  32'(rr_out_data),  32'h0000);
        check("idle out_sel",   32'(rr_out_sel),   32'h0);
        check("idle in_ready",  32'(rr_in_ready),  32'h0);

        // All channels valid with data 0x1000+i and the downstream ready.
        step();
        for (int i = 0; i < N; i++) set_word(i, 16'h1000 + 16'(i));
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        check("rr first in_ready", 32'(rr_in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr seq valid", 32'(rr_out_valid), 32'h1);
            check("rr seq sel",   32'(rr_out_sel),   32'(seq[k]));
            check("rr seq data",  32'(rr_out_data),  32'h1000 + 32'(seq[k]));
            check("rr seq ready", 32'(rr_in_ready),  32'(4'b0001 << ((seq[k] + 1) % N)));
            check("fp seq sel",   32'(fp_out_sel),   32'h0);
            check("fp seq ready", 32'(fp_in_ready),  32'h1);
        end

        // Backpressure: ch2 beat 0xBEEF held through a three-cycle stall.
        step();
        in_valid = '0;
        step();
        set_word(2, 16'hBEEF);
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        step();
        in_valid = 4'b0001;  // pending request that must stay blocked
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall valid", 32'(rr_out_valid), 32'h1);
            check("stall data",  32'(rr_out_data),  32'hBEEF);
            check("stall sel",   32'(rr_out_sel),   32'h2);
            check("stall ready", 32'(rr_in_ready),  32'h0);
            check("stall fp ready", 32'(fp_in_ready), 32'h0);
            step();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain pending", 32'(rr_out_valid), 32'h1);
        step();
        @(negedge clk);
        check("drained valid", 32'(rr_out_valid), 32'h0);
        check("drained data",  32'(rr_out_data),  32'hBEEF);
        check("drained sel",   32'(rr_out_sel),   32'h2);
        step();
        @(negedge clk);
        check("no dup valid",  32'(rr_out_valid), 32'h0);

        // Round-robin wrap: grant ch2 (ptr -> 3), then ch0 and ch1 request.
        step();
        set_word(2, 16'h2222);
        in_valid = 4'b0100;
        step();
        set_word(0, 16'hA000);
        set_word(1, 16'hA001);
        in_valid = 4'b0011;
        @(negedge clk);
        check("wrap ready0", 32'(rr_in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("wrap sel0",   32'(rr_out_sel),  32'h0);
        check("wrap data0",  32'(rr_out_data), 32'hA000);
        check("wrap ready1", 32'(rr_in_ready), 32'h2);
        @(posedge clk);
        @(negedge clk);
        check("wrap sel1",   32'(rr_out_sel),  32'h1);
        check("wrap data1",  32'(rr_out_data), 32'hA001);
        check("wrap fp sel", 32'(fp_out_sel),  32'h0);

        // Reset while a beat is stalled in the slot.
        step();
        in_valid = '0;
        step();
        set_word(3, 16'h3333);
        in_valid  = 4'b1000;
        out_ready = 1'b0;
        step();
        in_valid = '0;
        step();
        in_valid = 4'b1000;
        #1;
        reset = 1'b1;
        #1;
        check("async rst rr valid", 32'(rr_out_valid), 32'h0);
        check("async rst fp valid", 32'(fp_out_valid), 32'h0);
        check("async rst data",     32'(rr_out_data),  32'h0);
        check("async rst sel",      32'(rr_out_sel),   32'h0);
        check("async rst ready",    32'(rr_in_ready),  32'h0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post rst valid", 32'(rr_out_valid), 32'h0);
        check("post rst ready", 32'(rr_in_ready),  32'h8);
        @(posedge clk);
        @(negedge clk);
        check("post rst grant", 32'(rr_out_sel),   32'h3);
        step();
        in_valid = '0;

        // Randomized run with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) set_word(i, 16'($urandom));
            in_valid  = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
        end
        step();
        reset    = 1'b0;
        in_valid = '0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 16, data width of each channel in bits (>=1).
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Parameter SW, derived as max(1, clog2(N)), width of the channel-index signals.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_data  input  N*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  channel i offers a beat.
REQ-009 in_ready  output  N  channel i beat accepted this cycle when in_valid[i] & in_ready[i].
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data/out_sel hold a valid beat.
REQ-012 out_ready  input  1  downstream accepts the beat when out_valid & out_ready.
REQ-013 out_sel  output  SW  index of the channel the current out_data came from.

Function
REQ-014 Output stage SHALL be one register slot (out_data, out_sel, out_valid); latency from input acceptance to out_valid high = 1 clock.
REQ-015 can_load SHALL be !out_valid | out_ready, evaluated combinationally.
REQ-016 When can_load = 1 and at least one in_valid bit is set, exactly one channel g SHALL be granted; in_ready[g] = 1, all other in_ready bits 0.
REQ-017 When can_load = 0 or no in_valid bit is set, in_ready SHALL be all zeros.
REQ-018 in_ready SHALL depend combinationally on in_valid, out_valid, out_ready and the pointer; it SHALL never be asserted for a channel with in_valid = 0.
REQ-019 MODE 0: grant the first requesting channel searching from index ptr upward with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
REQ-020 MODE 0: on a grant to g, ptr SHALL become (g+1) mod N at the clock edge; with no grant, ptr SHALL hold.
REQ-021 MODE 1: grant the lowest-indexed requesting channel; ptr SHALL stay 0.
REQ-022 On a grant, at the clock edge: out_data <= in_data of channel g, out_sel <= g, out_valid <= 1.
REQ-023 Drain without a grant (out_valid & out_ready, no request): out_valid <= 0; out_data and out_sel SHALL hold their last values.
REQ-024 Drain and grant in the same cycle: the slot SHALL be replaced at that edge, sustaining one beat per clock with no bubble.
REQ-025 Stall (out_valid & !out_ready): out_data, out_sel and out_valid SHALL hold unchanged; no input accepted.
REQ-026 Input data SHALL be passed bit-exact; no arithmetic or width conversion.
REQ-027 Beats SHALL never be duplicated or dropped outside reset.

Reset
REQ-028 While reset is high, asynchronously: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, and in_ready = all zeros.
REQ-029 Reset asserted mid-operation SHALL discard any beat held in the output slot; no partial grant SHALL be completed.
REQ-030 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge at which reset is low.

Verification (N=4, WIDTH=16 unless stated)
REQ-031 Reset then idle: out_valid=0, out_data=0x0000, out_sel=0, in_ready=4'b0000.
REQ-032 MODE 0, all in_valid=1 continuously, out_ready=1, in_data ch i = 0x1000+i -> out_sel sequence 0,1,2,3,0,1 with one beat per clock; out_data matches 0x1000+out_sel.
REQ-033 MODE 1, same stimulus -> out_sel stays 0 every cycle; in_ready=4'b0001 each cycle.
REQ-034 Backpressure: ch2 only valid with 0xBEEF, out_ready=0 for 3 cycles -> out_valid=1, out_data=0xBEEF, out_sel=2 held; in_ready=0 during stall; raising out_ready completes the transfer exactly once.
REQ-035 MODE 0 wrap: ptr=3 (after granting ch2), requests on ch0 and ch1 only -> ch0 granted, then ch1.
REQ-036 Reset asserted while out_valid=1 and out_ready=0 -> out_valid drops to 0 immediately without waiting for a clock edge; the held beat is never delivered.
